led7_scan: RTL
==============

# led7_scan

Time-multiplexed driver for the eight-digit seven-segment display of the real-time clock. It takes the eight BCD/hex digit nibbles, decimal-point and blank masks produced by the clock/divider chain, and scans them onto the shared `led7_an_o`/`led7_seg_o` pins one digit at a time. The driver snapshots the digit inputs once per frame so that a digit never changes in the middle of a scan. It is the last stage before the board pins.

## Interface
- `DIV_P`, 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal range ≥2.
- `BLINK_HALF`, 62: full frames per blink half-period (~0.5 s at defaults); only used with blink enabled.
- `clk_i` input 1: system clock, 100 MHz.
- `rst_i` input 1: reset, asynchronous, active-high.
- `digits_i` input 32: eight nibbles; `[4k+3:4k]` is digit k; digit 0 is the rightmost display position, driven by `led7_an_o[0]`.
- `dp_i` input 8: decimal point request per digit, 1 = lit.
- `blank_i` input 8: 1 = digit k shows no segments and no dp.
- `blink_i` input 8: 1 = digit k blinks. Present only when `LED7_BLINK_EN` is defined.
- `led7_an_o` output 8: anode enables, active-low, one-hot-low.
- `led7_seg_o` output 8: `{dp,g,f,e,d,c,b,a}`, active-low.

## Operation
- **Prescaler `cnt`:**
  - Counts 0..DIV_P-1 and wraps to 0.
  - `tick` = (`cnt`==DIV_P-1).
- **Digit index `idx`:**
  - 3-bit, advances on `tick`.
  - Wraps 7→0; the wrap marks a frame boundary.
- **Shadow registers:**
  - `sh_dig`, `sh_dp` and `sh_blank` (plus `sh_blink` when blinking is compiled in) hold the inputs.
  - They load from the inputs on the first clock after reset deasserts (`init` flag set).
  - They also load on every cycle where `tick && idx==7`.
  - Input changes at any other time are invisible until the next frame.
- **Output registers, updated every cycle (1-cycle latency from `idx`):**
  - `led7_an_o` <= ~(8'b1 << `idx`).
  - `led7_seg_o` <= decode of `sh_dig[idx]`, with dp bit = ~`sh_dp[idx]`.
- **Decode:**
  - Nibble 0–9: standard digits.
  - Nibble A–F: hex glyphs A, b, C, d, E, F.
  - Example codes without dp: 0→8'hC0, 1→8'hF9, 8→8'h80, A→8'h88, F→8'h8E.
  - 8 with dp lit → 8'h00.
- **Blank:** when `sh_blank[idx]` is set, `led7_seg_o` = 8'hFF and the anode is still driven (keeps brightness uniform).
- **Reset values:**
  - `led7_an_o`=8'hFF, `led7_seg_o`=8'hFF.
  - `cnt`=0, `idx`=0, all shadow registers 0, blink phase 0.
- Reset asserted mid-frame forces outputs to 8'hFF asynchronously. Scanning restarts at digit 0 after reset release.

## Timing
- Reset release is counted as cycle 0 (first rising edge with `rst_i` low).
  - Shadow load happens at cycle 0.
  - Digit 0 appears on the outputs at cycle 1.
  - The first `tick` occurs at cycle DIV_P-1, and digit 1 appears at cycle DIV_P+1.
- Each digit is driven for exactly DIV_P cycles. A frame is 8·DIV_P cycles.
- On the cycle after `tick` at idx 7, `idx` becomes 0 and the new shadow contents are in place together. The following output update therefore shows the new digit 0; old and new data never mix within a frame.
- Output transitions are glitch-free: both output buses are registered and change on the same edge.

## Configuration
- Macro: `LED7_BLINK_EN`.
- **Defined:**
  - `blink_i` port and the frame counter are present.
  - The frame counter counts frames 0..BLINK_HALF-1 and toggles `phase` on wrap.
  - While `phase`=1, digits with `sh_blink` set render as blank (8'hFF).
  - The phase toggles only at frame boundaries.
- **Undefined:**
  - No `blink_i` port and no frame counter.
  - Behaviour is otherwise identical.

## Structure
- Package `led7_pkg` holds:
  - Segment code constants for 0–F.
  - `SEG_BLANK` = 8'hFF and `AN_OFF` = 8'hFF.
  - The `seg_t` 8-bit typedef.
- Sub-module `led7_decode` is purely combinational: nibble + dp → `seg_t`, using the package constants.
- `led7_scan` contains the prescaler, index, shadow registers, blink logic and output registers.

## Test plan
- **Reset values:** `rst_i`=1 with random inputs → `led7_an_o`=8'hFF and `led7_seg_o`=8'hFF; assert mid-scan and check they go to 8'hFF before the next clock edge.
- **Scan order:** DIV_P=4, `digits_i`=32'h76543210, no dp/blank → over 32 cycles the anodes step FE, FD, FB … 7F, 4 cycles each. Segments are C0, F9, A4, B0, 99, 92, 82, F8.
- **Frame snapshot:** change `digits_i` from 32'h11111111 to 32'h88888888 while idx=3 → digits 4–7 still show F9. The next frame shows 80 on all digits, starting exactly at the digit-0 slot.
- **DP and blank:** `digits_i`=32'h00000008, `dp_i`=8'h01, `blank_i`=8'h80 → digit 0 shows 8'h00, digit 7 shows 8'hFF with anode 7F still driven.
- **Hex glyphs:** `digits_i`=32'hFEDCBA98 → digit 2 shows 8'h88 (A), digit 7 shows 8'h8E (F).
- **Blink (`LED7_BLINK_EN`):** DIV_P=4, BLINK_HALF=2, `blink_i`=8'h01, digit 0 = 1 → digit 0 shows F9 for frames 0–1, FF for frames 2–3, F9 again for frame 4; other digits are unaffected.

Source files
------------

// File: rtl/led7_pkg.sv
// rtl/led7_pkg.sv - segment type and active-low glyph constants for the 7-segment scanner
package led7_pkg;

   typedef logic [7:0] seg_t;

   // {dp,g,f,e,d,c,b,a}, active-low, dp off
   localparam seg_t SEG_0 = 8'hC0;
   localparam seg_t SEG_1 = 8'hF9;
   localparam seg_t SEG_2 = 8'hA4;
   localparam seg_t SEG_3 = 8'hB0;
   localparam seg_t SEG_4 = 8'h99;
   localparam seg_t SEG_5 = 8'h92;
   localparam seg_t SEG_6 = 8'h82;
   localparam seg_t SEG_7 = 8'hF8;
   localparam seg_t SEG_8 = 8'h80;
   localparam seg_t SEG_9 = 8'h90;
   localparam seg_t SEG_A = 8'h88;
   localparam seg_t SEG_B = 8'h83;
   localparam seg_t SEG_C = 8'hC6;
   localparam seg_t SEG_D = 8'hA1;
   localparam seg_t SEG_E = 8'h86;
   localparam seg_t SEG_F = 8'h8E;

   localparam seg_t       SEG_BLANK = 8'hFF;
   localparam logic [7:0] AN_OFF    = 8'hFF;

endpackage

// File: rtl/led7_decode.sv
// rtl/led7_decode.sv - combinational nibble + dp to active-low segment pattern
module led7_decode
   import led7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   output seg_t       seg
);

   seg_t glyph;

   always_comb begin
      glyph = SEG_BLANK;
      case (nibble)
         4'h0: glyph = SEG_0;
         4'h1: glyph = SEG_1;
         4'h2: glyph = SEG_2;
         4'h3: glyph = SEG_3;
         4'h4: glyph = SEG_4;
         4'h5: glyph = SEG_5;
         4'h6: glyph = SEG_6;
         4'h7: glyph = SEG_7;
         4'h8: glyph = SEG_8;
         4'h9: glyph = SEG_9;
         4'hA: glyph = SEG_A;
         4'hB: glyph = SEG_B;
         4'hC: glyph = SEG_C;
         4'hD: glyph = SEG_D;
         4'hE: glyph = SEG_E;
         4'hF: glyph = SEG_F;
         default: glyph = SEG_BLANK;
      endcase
   end

   assign seg = {~dp, glyph[6:0]};

endmodule

// File: rtl/led7_scan.sv
// rtl/led7_scan.sv - 8-digit multiplexed 7-segment driver with per-frame input snapshot; LED7_BLINK_EN adds blinking
module led7_scan
   import led7_pkg::*;
#(
   parameter int DIV_P      = 100000,
   parameter int BLINK_HALF = 62
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] digits_i,
   input  logic [7:0]  dp_i,
   input  logic [7:0]  blank_i,
`ifdef LED7_BLINK_EN
   input  logic [7:0]  blink_i,
`endif
   output logic [7:0]  led7_an_o,
   output logic [7:0]  led7_seg_o
);

   localparam int CW = $clog2(DIV_P);

   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic          init;
   logic [31:0]   sh_dig;
   logic [7:0]    sh_dp;
   logic [7:0]    sh_blank;
   logic          tick;
   logic          frame_end;
   logic          blank_now;
   logic [3:0]    nibble;
   seg_t          dec_seg;

   assign tick      = (cnt == CW'(DIV_P - 1));
   assign frame_end = tick && (idx == 3'd7);

   // The counters hold during the init cycle so digit 0 gets a full DIV_P slot.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt      <= '0;
         idx      <= '0;
         init     <= 1'b1;
         sh_dig   <= '0;
         sh_dp    <= '0;
         sh_blank <= '0;
      end else begin
         init <= 1'b0;
         if (init || frame_end) begin
            sh_dig   <= digits_i;
            sh_dp    <= dp_i;
            sh_blank <= blank_i;
         end
         if (!init) begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
               idx <= idx + 3'd1;
         end
      end
   end

`ifdef LED7_BLINK_EN
   localparam int FW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   logic [7:0]    sh_blink;
   logic [FW-1:0] fcnt;
   logic          phase;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sh_blink <= '0;
         fcnt     <= '0;
         phase    <= 1'b0;
      end else begin
         if (init || frame_end)
            sh_blink <= blink_i;
         if (frame_end) begin
            if (fcnt == FW'(BLINK_HALF - 1)) begin
               fcnt  <= '0;
               phase <= ~phase;
            end else begin
               fcnt <= fcnt + 1'b1;
            end
         end
      end
   end

   assign blank_now = sh_blank[idx] | (phase & sh_blink[idx]);
`else
   logic unused_blink_half;
   assign unused_blink_half = BLINK_HALF[0];
   assign blank_now         = sh_blank[idx];
`endif

   assign nibble = sh_dig[idx*4 +: 4];

   led7_decode u_decode (
      .nibble (nibble),
      .dp     (sh_dp[idx]),
      .seg    (dec_seg)
   );

   // Blanked digits keep their anode driven so every slot draws the same duty.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         led7_an_o  <= AN_OFF;
         led7_seg_o <= SEG_BLANK;
      end else if (init) begin
         led7_an_o  <= AN_OFF;
         led7_seg_o <= SEG_BLANK;
      end else begin
         led7_an_o  <= ~(8'b1 << idx);
         led7_seg_o <= blank_now ? SEG_BLANK : dec_seg;
      end
   end

endmodule
